ahb_decoder_dp: RTL and testbench

- Next-generation AHB slave-select decoder for one master-side layer of the bus matrix.
- Performs a combinational address-phase decode over a parametrised region map, with optional boot remap.
- Registers the data-phase select that drives the response mux.
- Embeds a default slave that returns the two-cycle AHB ERROR response for unmapped NONSEQ/SEQ transfers, and counts decode errors.

---
 rtl/AHB_package.sv | 34 +++
 rtl/ahb_default_slave.sv | 72 +++++++
 rtl/ahb_decoder_dp.sv | 93 +++++++++
 tb/tb_ahb_decoder_dp.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/AHB_package.sv
// Shared AHB types for the slave-select decoder: transfer/response encodings,
// default-slave FSM states and the address-map array type with its default map.
package AHB_package;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_type;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_type;

  typedef enum logic [1:0] {
    DEF_OKAY = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_type;

  localparam int MAP_SLAVES = 4;
  localparam int MAP_AW     = 32;

  typedef logic [MAP_SLAVES-1:0][MAP_AW-1:0] addr_map_t;

  // Element [0] is the rightmost entry: slave 0 owns the boot region at 0x0.
  localparam addr_map_t DEFAULT_LOW_ADDR  = {32'h4000_0000, 32'h2000_0000,
                                             32'h1000_0000, 32'h0000_0000};
  localparam addr_map_t DEFAULT_HIGH_ADDR = {32'h4FFF_FFFF, 32'h2000_0FFF,
                                             32'h1000_FFFF, 32'h0000_FFFF};

endpackage

// File: rtl/ahb_default_slave.sv
// AHB default slave: two-cycle ERROR response for captured decode misses and a
// saturating decode-error counter with synchronous clear.
module ahb_default_slave
  import AHB_package::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     hclk,
  input  logic                     hreset,
  input  logic                     hready,
  input  logic                     miss,
  input  logic                     err_cnt_clr,
  output logic                     def_hreadyout,
  output logic                     def_hresp,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt
);

  def_state_type              r_state;
  def_state_type              w_state_nxt;
  hresp_type                  w_hresp;
  logic [ERR_CNT_WIDTH-1:0]   r_err_cnt;
  logic                       w_capture_miss;

  assign w_capture_miss = hready && miss;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state <= DEF_OKAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    def_hreadyout = 1'b1;
    w_hresp       = HRESP_OKAY;
    case (r_state)
      DEF_OKAY: begin
        if (w_capture_miss) w_state_nxt = DEF_ERR1;
      end
      DEF_ERR1: begin
        def_hreadyout = 1'b0;
        w_hresp       = HRESP_ERROR;
        w_state_nxt   = DEF_ERR2;
      end
      DEF_ERR2: begin
        w_hresp     = HRESP_ERROR;
        w_state_nxt = w_capture_miss ? DEF_ERR1 : DEF_OKAY;
      end
      default: begin
        w_state_nxt = DEF_OKAY;
      end
    endcase
  end

  assign def_hresp = w_hresp;

  // A clear coinciding with a new miss still records that miss.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_err_cnt <= '0;
    end else if (err_cnt_clr) begin
      r_err_cnt <= w_capture_miss ? ERR_CNT_WIDTH'(1) : '0;
    end else if (w_capture_miss && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERR_CNT_WIDTH'(1);
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: rtl/ahb_decoder_dp.sv
// AHB slave-select decoder for one master layer: combinational address decode
// with boot remap, registered data-phase select and an embedded default slave.
module ahb_decoder_dp
  import AHB_package::*;
#(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 4,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] LOW_ADDR  = DEFAULT_LOW_ADDR,
  parameter logic [SLAVE_NUM-1:0][AHB_ADDR_WIDTH-1:0] HIGH_ADDR = DEFAULT_HIGH_ADDR,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_LOW  = '0,
  parameter logic [AHB_ADDR_WIDTH-1:0] REMAP_HIGH = AHB_ADDR_WIDTH'(32'h0000_FFFF),
  parameter int REMAP_SLV      = 1,
  parameter int ERR_CNT_WIDTH  = 8
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  htrans_type                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  input  logic                      err_cnt_clr,
  output logic [SLAVE_NUM-1:0]      hsel,
  output logic [SLAVE_NUM-1:0]      hsel_dp,
  output logic                      default_sel_dp,
  output logic                      def_hreadyout,
  output logic                      def_hresp,
  output logic [ERR_CNT_WIDTH-1:0]  err_cnt
);

  logic [SLAVE_NUM-1:0] w_decoded;
  logic                 w_active;
  logic                 w_miss;
  logic [SLAVE_NUM-1:0] r_hsel_dp;
  logic                 r_default_sel_dp;

  // Inclusive range test done with borrow bits so a zero bound is not a
  // constant comparison.
  function automatic logic in_range(input logic [AHB_ADDR_WIDTH-1:0] a,
                                    input logic [AHB_ADDR_WIDTH-1:0] lo,
                                    input logic [AHB_ADDR_WIDTH-1:0] hi);
    logic [AHB_ADDR_WIDTH:0] d_lo;
    logic [AHB_ADDR_WIDTH:0] d_hi;
    d_lo = {1'b0, a} - {1'b0, lo};
    d_hi = {1'b0, hi} - {1'b0, a};
    return !d_lo[AHB_ADDR_WIDTH] && !d_hi[AHB_ADDR_WIDTH];
  endfunction

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_decoded = '0;
    for (int i = SLAVE_NUM - 1; i >= 0; i--) begin
      if (in_range(haddr, LOW_ADDR[i], HIGH_ADDR[i])) begin
        w_decoded    = '0;
        w_decoded[i] = 1'b1;
      end
    end
    if (hremap && in_range(haddr, REMAP_LOW, REMAP_HIGH)) begin
      w_decoded            = '0;
      w_decoded[REMAP_SLV] = 1'b1;
    end
  end

  assign w_active = (htrans == NONSEQ) || (htrans == SEQ);
  assign hsel     = w_active ? w_decoded : '0;
  assign w_miss   = w_active && (w_decoded == '0);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_hsel_dp        <= '0;
      r_default_sel_dp <= 1'b0;
    end else if (hready) begin
      r_hsel_dp        <= hsel;
      r_default_sel_dp <= w_miss;
    end
  end

  assign hsel_dp        = r_hsel_dp;
  assign default_sel_dp = r_default_sel_dp;

  ahb_default_slave #(
    .ERR_CNT_WIDTH (ERR_CNT_WIDTH)
  ) u_default_slave (
    .hclk          (hclk),
    .hreset        (hreset),
    .hready        (hready),
    .miss          (w_miss),
    .err_cnt_clr   (err_cnt_clr),
    .def_hreadyout (def_hreadyout),
    .def_hresp     (def_hresp),
    .err_cnt       (err_cnt)
  );

endmodule

// File: tb/tb_ahb_decoder_dp.sv
// Directed bench for ahb_decoder_dp: decode boundaries, remap, filtering,
// wait states, ERROR sequencing, counter saturation/clear and async reset.
module tb_ahb_decoder_dp;
  import AHB_package::*;

  logic        hclk;
  logic        hreset;
  logic [31:0] haddr;
  htrans_type  htrans;
  logic        hready;
  logic        hremap;
  logic        err_cnt_clr;
  logic [3:0]  hsel;
  logic [3:0]  hsel_dp;
  logic        default_sel_dp;
  logic        def_hreadyout;
  logic        def_hresp;
  logic [7:0]  err_cnt;

  int tests_run;
  int tests_failed;

  ahb_decoder_dp dut (
    .hclk           (hclk),
    .hreset         (hreset),
    .haddr          (haddr),
    .htrans         (htrans),
    .hready         (hready),
    .hremap         (hremap),
    .err_cnt_clr    (err_cnt_clr),
    .hsel           (hsel),
    .hsel_dp        (hsel_dp),
    .default_sel_dp (default_sel_dp),
    .def_hreadyout  (def_hreadyout),
    .def_hresp      (def_hresp),
    .err_cnt        (err_cnt)
  );

  // clock / reset
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input htrans_type t, input logic [31:0] a, input logic rdy);
    htrans = t;
    haddr  = a;
    hready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic rdy_exp, input logic resp_exp);
    check({tag, "_hreadyout"}, {31'd0, def_hreadyout}, {31'd0, rdy_exp});
    check({tag, "_hresp"},     {31'd0, def_hresp},     {31'd0, resp_exp});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    hreset       = 1'b1;
    haddr        = '0;
    htrans       = IDLE;
    hready       = 1'b1;
    hremap       = 1'b0;
    err_cnt_clr  = 1'b0;
    step();
    step();
    hreset = 1'b0;
    #1;

    // reset state
    check("rst_hsel_dp", {28'd0, hsel_dp}, 32'h0);
    check("rst_default_sel_dp", {31'd0, default_sel_dp}, 32'h0);
    check_resp("rst", 1'b1, 1'b0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'h0);

    // boundary decode
    drive(NONSEQ, 32'h1000_FFFF, 1'b1);
    check("bnd_top_hsel", {28'd0, hsel}, 32'h2);
    step();
    check("bnd_top_hsel_dp", {28'd0, hsel_dp}, 32'h2);
    drive(NONSEQ, 32'h1001_0000, 1'b1);
    check("bnd_plus1_hsel", {28'd0, hsel}, 32'h0);
    step();
    check("bnd_plus1_default_sel_dp", {31'd0, default_sel_dp}, 32'h1);
    check("bnd_plus1_hsel_dp", {28'd0, hsel_dp}, 32'h0);
    check_resp("bnd_err1", 1'b0, 1'b1);
    check("bnd_err_cnt", {24'd0, err_cnt}, 32'h1);
    drive(IDLE, 32'h0, 1'b0);
    step();
    check_resp("bnd_err2", 1'b1, 1'b1);
    check("bnd_hold_default_sel_dp", {31'd0, default_sel_dp}, 32'h1);
    drive(IDLE, 32'h0, 1'b1);
    step();
    check_resp("bnd_okay", 1'b1, 1'b0);
    check("bnd_default_sel_dp_clr", {31'd0, default_sel_dp}, 32'h0);
    check("bnd_err_cnt_after", {24'd0, err_cnt}, 32'h1);

    // other region edges (combinational only)
    drive(SEQ, 32'h4FFF_FFFF, 1'b0);
    check("edge_s3_top", {28'd0, hsel}, 32'h8);
    drive(SEQ, 32'h5000_0000, 1'b0);
    check("edge_s3_plus1", {28'd0, hsel}, 32'h0);
    drive(NONSEQ, 32'h2000_0FFF, 1'b0);
    check("edge_s2_top", {28'd0, hsel}, 32'h4);
    drive(NONSEQ, 32'h2000_1000, 1'b0);
    check("edge_s2_plus1", {28'd0, hsel}, 32'h0);
    drive(NONSEQ, 32'h4000_0000, 1'b0);
    check("edge_s3_base", {28'd0, hsel}, 32'h8);

    // remap
    hremap = 1'b1;
    drive(NONSEQ, 32'h0000_0100, 1'b0);
    check("remap_on", {28'd0, hsel}, 32'h2);
    drive(NONSEQ, 32'h0001_0000, 1'b0);
    check("remap_outside", {28'd0, hsel}, 32'h0);
    hremap = 1'b0;
    drive(NONSEQ, 32'h0000_0100, 1'b0);
    check("remap_off", {28'd0, hsel}, 32'h1);

    // filtering: BUSY and IDLE to unmapped space
    drive(BUSY, 32'h3000_0000, 1'b1);
    check("busy_hsel", {28'd0, hsel}, 32'h0);
    step();
    check_resp("busy_no_err", 1'b1, 1'b0);
    check("busy_default_sel_dp", {31'd0, default_sel_dp}, 32'h0);
    drive(IDLE, 32'h3000_0000, 1'b1);
    check("idle_hsel", {28'd0, hsel}, 32'h0);
    step();
    check_resp("idle_no_err", 1'b1, 1'b0);
    check("idle_err_cnt", {24'd0, err_cnt}, 32'h1);

    // wait states hold the data-phase select
    drive(NONSEQ, 32'h2000_0000, 1'b1);
    step();
    check("ws_first", {28'd0, hsel_dp}, 32'h4);
    drive(NONSEQ, 32'h1000_0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("ws_hold%0d", i), {28'd0, hsel_dp}, 32'h4);
    end
    drive(NONSEQ, 32'h1000_0000, 1'b1);
    step();
    check("ws_release", {28'd0, hsel_dp}, 32'h2);

    // back-to-back misses
    err_cnt_clr = 1'b1;
    drive(IDLE, 32'h0, 1'b1);
    step();
    err_cnt_clr = 1'b0;
    check("b2b_clr", {24'd0, err_cnt}, 32'h0);
    drive(NONSEQ, 32'h3000_0000, 1'b1);
    step();
    check_resp("b2b_err1a", 1'b0, 1'b1);
    drive(IDLE, 32'h0, 1'b0);
    step();
    check_resp("b2b_err2a", 1'b1, 1'b1);
    drive(NONSEQ, 32'h3000_0000, 1'b1);
    step();
    check_resp("b2b_err1b", 1'b0, 1'b1);
    check("b2b_cnt2", {24'd0, err_cnt}, 32'h2);
    drive(IDLE, 32'h0, 1'b0);
    step();
    check_resp("b2b_err2b", 1'b1, 1'b1);
    drive(IDLE, 32'h0, 1'b1);
    step();
    check_resp("b2b_okay", 1'b1, 1'b0);
    check("b2b_cnt_final", {24'd0, err_cnt}, 32'h2);

    // mapped transfer accepted in ERR2 returns to OKAY
    drive(SEQ, 32'h3000_0000, 1'b1);
    step();
    drive(IDLE, 32'h0, 1'b0);
    step();
    check_resp("err2_map_in_err2", 1'b1, 1'b1);
    drive(NONSEQ, 32'h0000_0000, 1'b1);
    step();
    check_resp("err2_map_okay", 1'b1, 1'b0);
    check("err2_map_hsel_dp", {28'd0, hsel_dp}, 32'h1);
    check("err2_map_cnt", {24'd0, err_cnt}, 32'h3);

    // saturation, clear+miss, clear alone
    drive(NONSEQ, 32'h3000_0000, 1'b1);
    for (int i = 0; i < 260; i++) step();
    check("sat_ff", {24'd0, err_cnt}, 32'hFF);
    step();
    check("sat_hold", {24'd0, err_cnt}, 32'hFF);
    err_cnt_clr = 1'b1;
    step();
    check("clr_with_miss", {24'd0, err_cnt}, 32'h1);
    drive(IDLE, 32'h0, 1'b1);
    step();
    err_cnt_clr = 1'b0;
    check("clr_alone", {24'd0, err_cnt}, 32'h0);
    step();
    step();

    // async reset in ERR1
    drive(NONSEQ, 32'h3000_0000, 1'b1);
    step();
    check_resp("rst_pre_err1", 1'b0, 1'b1);
    check("rst_pre_cnt", {24'd0, err_cnt}, 32'h1);
    drive(IDLE, 32'h0, 1'b0);
    hreset = 1'b1;
    #1;
    check("arst_hsel_dp", {28'd0, hsel_dp}, 32'h0);
    check("arst_default_sel_dp", {31'd0, default_sel_dp}, 32'h0);
    check_resp("arst", 1'b1, 1'b0);
    check("arst_err_cnt", {24'd0, err_cnt}, 32'h0);
    #1;
    hreset = 1'b0;
    drive(IDLE, 32'h0, 1'b1);
    step();
    drive(NONSEQ, 32'h2000_0800, 1'b1);
    check("post_rst_hsel", {28'd0, hsel}, 32'h4);
    step();
    check("post_rst_hsel_dp", {28'd0, hsel_dp}, 32'h4);
    check_resp("post_rst", 1'b1, 1'b0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
